// File: rtl/add_sat_pipe.sv
// rtl/add_sat_pipe.sv - two-stage multi-lane adder with optional per-lane saturation and 8-bit split mode
module add_sat_pipe #(
  parameter int LANES = 4,
  parameter int W     = 16
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  input  logic [LANES-1:0]   cin,
  input  logic [LANES-1:0]   sat,
  input  logic [LANES-1:0]   eightbit,
  input  logic [LANES-1:0]   hicinh,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] r,
  output logic [LANES-1:0]   co,
  output logic [LANES-1:0]   sat_flags,
  input  logic               clr_flags
);

  logic               adv;
  logic               s1_valid_q;
  logic [LANES*W-1:0] a_q, b_q;
  logic [LANES-1:0]   cin_q, sat_q, eb_q, hic_q;

  logic               out_valid_q;
  logic [LANES*W-1:0] r_q, r_d;
  logic [LANES-1:0]   co_q, co_d;
  logic [LANES-1:0]   clamp_q, clamp_d;
  logic [LANES-1:0]   flags_q, flags_d;

  assign adv = out_ready | ~out_valid_q;

  // All arithmetic sits between the stage-1 registers and the stage-2 registers.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0] al, bl, lane_r;
    logic [W:0]   full;
    logic [8:0]   lo;
    logic [W-8:0] hi;
    logic         c8, lane_co, lane_clamp;

    assign al = a_q[i*W +: W];
    assign bl = b_q[i*W +: W];

    always_comb begin
      full       = {1'b0, al} + {1'b0, bl} + (W+1)'(cin_q[i]);
      lo         = {1'b0, al[7:0]} + {1'b0, bl[7:0]} + 9'(cin_q[i]);
      c8         = lo[8] & ~hic_q[i];
      hi         = {1'b0, al[W-1:8]} + {1'b0, bl[W-1:8]} + (W-7)'(c8);
      lane_r     = full[W-1:0];
      lane_co    = full[W];
      lane_clamp = 1'b0;
      if (!eb_q[i]) begin
        if (sat_q[i] && !bl[W-1] && full[W]) begin
          lane_r     = '1;
          lane_clamp = 1'b1;
        end else if (sat_q[i] && bl[W-1] && !full[W]) begin
          lane_r     = '0;
          lane_clamp = 1'b1;
        end
      end else begin
        // High part always wraps; only the low byte can clamp.
        lane_co = hi[W-8];
        lane_r  = {hi[W-9:0], lo[7:0]};
        if (sat_q[i] && !bl[7] && lo[8]) begin
          lane_r[7:0] = 8'hFF;
          lane_clamp  = 1'b1;
        end else if (sat_q[i] && bl[7] && !lo[8]) begin
          lane_r[7:0] = 8'h00;
          lane_clamp  = 1'b1;
        end
      end
    end

    assign r_d[i*W +: W] = lane_r;
    assign co_d[i]       = lane_co;
    assign clamp_d[i]    = lane_clamp;
  end

  // A flag set by this cycle's output transfer beats a simultaneous clear.
  assign flags_d = (clr_flags ? '0 : flags_q) | ({LANES{out_valid_q & out_ready}} & clamp_q);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= '0;
      sat_q       <= '0;
      eb_q        <= '0;
      hic_q       <= '0;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      co_q        <= '0;
      clamp_q     <= '0;
      flags_q     <= '0;
    end else begin
      if (adv) begin
        s1_valid_q  <= in_valid;
        a_q         <= a;
        b_q         <= b;
        cin_q       <= cin;
        sat_q       <= sat;
        eb_q        <= eightbit;
        hic_q       <= hicinh;
        out_valid_q <= s1_valid_q;
        r_q         <= r_d;
        co_q        <= co_d;
        clamp_q     <= clamp_d;
      end
      flags_q <= flags_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign co        = co_q;
  assign sat_flags = flags_q;

endmodule

// File: tb/tb_add_sat_pipe.sv
// tb/tb_add_sat_pipe.sv - scoreboard bench for add_sat_pipe (LANES=4, W=16)
module tb_add_sat_pipe;

  typedef struct {
    logic [63:0] r;
    logic [3:0]  co;
    logic [3:0]  clamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, clr_flags;
  logic [63:0] a_v, b_v, r;
  logic [3:0]  cin_v, sat_v, eb_v, hic_v, co, sat_flags;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  exp_t        dir_exp;
  logic        dir_valid = 1'b0;
  logic        in_xfer;
  logic        hold_chk;
  logic [63:0] hold_r;
  logic [3:0]  exp_flags = '0;

  always #5 clk = ~clk;

  add_sat_pipe #(.LANES(4), .W(16)) dut (
    .sys_clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a_v), .b(b_v), .cin(cin_v), .sat(sat_v), .eightbit(eb_v), .hicinh(hic_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .co(co), .sat_flags(sat_flags), .clr_flags(clr_flags)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic [3:0] ci, input logic [3:0] st,
                                 input logic [3:0] eb, input logic [3:0] hc);
    exp_t e;
    e.r = '0; e.co = '0; e.clamp = '0;
    for (int i = 0; i < 4; i++) begin
      int unsigned al, bl, s, lo, hi, lob, res, c7;
      al = av[i*16 +: 16];
      bl = bv[i*16 +: 16];
      if (!eb[i]) begin
        s = al + bl + ci[i];
        e.co[i] = (s >> 16) & 1;
        res = s & 32'hFFFF;
        if (st[i] && ((bl >> 15) & 1) == 0 && e.co[i]) begin res = 32'hFFFF; e.clamp[i] = 1'b1; end
        if (st[i] && ((bl >> 15) & 1) == 1 && !e.co[i]) begin res = 0; e.clamp[i] = 1'b1; end
      end else begin
        lo  = (al & 255) + (bl & 255) + ci[i];
        c7  = (lo >> 8) & 1;
        hi  = (al >> 8) + (bl >> 8) + (hc[i] ? 0 : c7);
        e.co[i] = (hi >> 8) & 1;
        lob = lo & 255;
        if (st[i] && ((bl >> 7) & 1) == 0 && c7 == 1) begin lob = 255; e.clamp[i] = 1'b1; end
        if (st[i] && ((bl >> 7) & 1) == 1 && c7 == 0) begin lob = 0; e.clamp[i] = 1'b1; end
        res = ((hi & 255) << 8) | lob;
      end
      e.r[i*16 +: 16] = res[15:0];
    end
    return e;
  endfunction

  // Called mid-cycle with inputs settled: scores the coming edge, then advances one cycle.
  task automatic tick();
    exp_t e;
    logic [3:0] nflags;
    #1;
    in_xfer  = 1'b0;
    hold_chk = 1'b0;
    nflags   = '0;
    if (!reset) begin
      nflags = clr_flags ? 4'b0 : exp_flags;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("r", r, e.r);
          chk("co", co, e.co);
          nflags |= e.clamp;
        end
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 1'b0);
        hold_chk = 1'b1;
        hold_r   = r;
      end
      if (in_valid && in_ready) begin
        in_xfer = 1'b1;
        sb.push_back(dir_valid ? dir_exp : model(a_v, b_v, cin_v, sat_v, eb_v, hic_v));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (reset) sb.delete();
    exp_flags = nflags;
    chk("sat_flags", sat_flags, exp_flags);
    if (hold_chk) chk("stall_r_stable", r, hold_r);
  endtask

  task automatic set_lane0(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                           input logic st, input logic eb, input logic hc);
    a_v = {48'h0, av}; b_v = {48'h0, bv};
    cin_v = {3'b0, ci}; sat_v = {3'b0, st}; eb_v = {3'b0, eb}; hic_v = {3'b0, hc};
  endtask

  task automatic send_dir(input logic [15:0] av, input logic [15:0] bv, input logic st,
                          input logic eb, input logic hc, input logic [15:0] er,
                          input logic eco, input logic ecl);
    int guard = 0;
    set_lane0(av, bv, 1'b0, st, eb, hc);
    dir_exp.r = {48'h0, er}; dir_exp.co = {3'b0, eco}; dir_exp.clamp = {3'b0, ecl};
    dir_valid = 1'b1;
    in_valid  = 1'b1;
    do begin tick(); guard++; end while (!in_xfer && guard < 20);
    if (!in_xfer) chk("send_timeout", 1'b0, 1'b1);
    in_valid  = 1'b0;
    dir_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && guard < 50) begin tick(); guard++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic rand_ops();
    a_v = {$urandom, $urandom}; b_v = {$urandom, $urandom};
    cin_v = 4'($urandom); sat_v = 4'($urandom); eb_v = 4'($urandom); hic_v = 4'($urandom);
  endtask

  initial begin
    int idx, stall_left, guard;
    logic stalled;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    set_lane0(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_r", r, 64'h0);
    chk("rst_co", co, 4'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed saturation / 8-bit cases
    send_dir(16'hFFF0, 16'h0020, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    send_dir(16'h0010, 16'hFFE0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    send_dir(16'h0010, 16'hFFE0, 1'b0, 1'b0, 1'b0, 16'hFFF0, 1'b0, 1'b0);
    send_dir(16'h12F0, 16'h0020, 1'b1, 1'b1, 1'b1, 16'h12FF, 1'b0, 1'b1);
    send_dir(16'h12F0, 16'h0020, 1'b1, 1'b1, 1'b0, 16'h13FF, 1'b0, 1'b1);
    drain();
    chk("flag_lane0_after_clamp", sat_flags[0], 1'b1);

    // Three back-to-back inputs with a 3-cycle output stall
    out_ready = 1'b1; idx = 0; stall_left = 0; stalled = 1'b0; guard = 0;
    rand_ops();
    while ((idx < 3 || stall_left > 0) && guard < 50) begin
      in_valid = (idx < 3);
      if (!stalled && out_valid) begin stalled = 1'b1; stall_left = 3; end
      out_ready = (stall_left == 0);
      tick();
      guard++;
      if (stall_left > 0) stall_left--;
      if (in_xfer) begin idx++; rand_ops(); end
    end
    chk("b2b_sent", idx, 3);
    drain();

    // Reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    rand_ops(); tick(); rand_ops(); tick(); rand_ops(); tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_sat_flags", sat_flags, 4'h0);
    chk("rst2_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    drain();

    // Clear racing a clamping output transfer
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    out_ready = 1'b0;
    send_dir(16'hFFF0, 16'h0020, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1);
    guard = 0;
    while (!out_valid && guard < 10) begin tick(); guard++; end
    clr_flags = 1'b1; out_ready = 1'b1;
    tick();
    chk("clr_vs_set_flag0", sat_flags[0], 1'b1);
    tick();
    chk("clr_alone_flag0", sat_flags[0], 1'b0);
    clr_flags = 1'b0;

    // Random traffic with random backpressure and clears
    for (int n = 0; n < 300; n++) begin
      rand_ops();
      in_valid = ($urandom_range(0, 4) != 0);
      guard = 0;
      do begin
        out_ready = ($urandom_range(0, 3) != 0);
        clr_flags = ($urandom_range(0, 9) == 0);
        tick();
        guard++;
      end while (in_valid && !in_xfer && guard < 30);
    end
    clr_flags = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_sat_pipe.md
ADD_SAT_PIPE -- requirements
Module: add_sat_pipe

Interface
REQ-001 SHALL provide parameter LANES, default 4: number of independent adder lanes.
REQ-002 SHALL provide parameter W, default 16: lane width in bits; W even, W >= 16.
REQ-003 SHALL have port sys_clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have in_valid/in_ready (input/output, 1 each): operand handshake; a transfer occurs when both are high at a rising edge.
REQ-006 SHALL have a, b (inputs, LANES*W): per-lane operands; lane i = bits [i*W +: W]; a unsigned, b two's-complement.
REQ-007 SHALL have cin, sat, eightbit, hicinh (inputs, LANES each): per-lane carry-in, saturate enable, 8-bit mode, high-part carry inhibit; all sampled with the operands.
REQ-008 SHALL have out_valid/out_ready (output/input, 1 each): result handshake.
REQ-009 SHALL have r (output, LANES*W): per-lane results; co (output, LANES): per-lane carry out of bit W-1.
REQ-010 SHALL have sat_flags (output, LANES): sticky per-lane "clamp occurred" flags; clr_flags (input, 1): clears them.

Function
REQ-011 SHALL be a two-stage pipeline: stage 1 registers operands/controls, stage 2 registers r/co; latency 2 cycles from input transfer to out_valid with no backpressure.
REQ-012 SHALL advance both stages only when adv = out_ready | ~out_valid; in_ready SHALL equal adv.
REQ-013 SHALL hold r, co, out_valid and stage 1 unchanged while out_valid=1 and out_ready=0.
REQ-014 SHALL sustain one result per cycle with out_ready held high; results in input order, none lost or duplicated.
REQ-015 SHALL load an empty (valid=0) bubble into a stage whose upstream had no valid data at an advance.
REQ-016 With eightbit=0: sum = a + b + cin over W bits; co = carry out of bit W-1.
REQ-017 With eightbit=0, sat=1: b[W-1]=0 and carry -> r = all ones; b[W-1]=1 and no carry -> r = 0; otherwise r = sum.
REQ-018 With eightbit=1: low byte = a[7:0]+b[7:0]+cin; carry into bit 8 = carry out of bit 7 unless hicinh=1, then 0.
REQ-019 With eightbit=1: bits W-1:8 add with that carry and always wrap; co = carry out of bit W-1.
REQ-020 With eightbit=1, sat=1: clamp only the low byte, using b[7] and carry out of bit 7 per the REQ-017 rule (0xFF or 0x00).
REQ-021 With sat=0: the result SHALL wrap and SHALL NOT set sat_flags.
REQ-022 SHALL set sat_flags[i] at each output transfer (out_valid & out_ready) whose lane-i result was clamped.
REQ-023 clr_flags=1 SHALL zero sat_flags next edge; a set in the same cycle SHALL win for that lane.
REQ-024 Lanes SHALL be fully independent; no carry crosses lane boundaries.
REQ-025 Carry and clamp SHALL be computed in stage 1->2; stage 2 holds no arithmetic.

Reset
REQ-026 On reset=1 at an edge: both stage valids, out_valid, r, co and sat_flags SHALL become 0; in-flight data SHALL be discarded.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Reset SHALL take priority over handshakes and clr_flags.

Verification
REQ-029 Lane 0, a=0xFFF0, b=0x0020, cin=0, sat=1, eightbit=0 -> r=0xFFFF, co=1, sat_flags[0]=1 after output transfer.
REQ-030 a=0x0010, b=0xFFE0, sat=1 -> r=0x0000, co=0, flag set; same with sat=0 -> r=0xFFF0, no flag.
REQ-031 eightbit=1, sat=1, a=0x12F0, b=0x0020: hicinh=1 -> r=0x12FF; hicinh=0 -> r=0x13FF; co=0 both.
REQ-032 Three back-to-back inputs, out_ready low for 3 cycles after the first out_valid -> in_ready=0 during stall, r stable, all three delivered in order, none duplicated.
REQ-033 Reset asserted with both stages valid -> next cycle out_valid=0, sat_flags=0, in_ready=1; no stale result later.
REQ-034 clr_flags=1 in the same cycle as a clamping output transfer -> flag reads 1; clr_flags alone next cycle -> 0.
